// File: rtl/adrv9001_dgpio_ctrl.sv
// ADRV9001 DGPIO controller: pad direction/level, timed pulses,
// synchronised glitch-filtered inputs and sticky edge interrupts.
module adrv9001_dgpio_ctrl #(
    parameter int NUM_PINS = 12,
    parameter int FILT_W   = 8,
    parameter int PULSE_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PINS-1:0] cfg_dir,
    input  logic [NUM_PINS-1:0] cfg_out,
    input  logic [FILT_W-1:0]   cfg_filt_len,
    input  logic [NUM_PINS-1:0] cfg_rise_en,
    input  logic [NUM_PINS-1:0] cfg_fall_en,
    input  logic [NUM_PINS-1:0] irq_clr,
    input  logic [NUM_PINS-1:0] pulse_start,
    input  logic [PULSE_W-1:0]  pulse_len,
    input  logic [NUM_PINS-1:0] dgpio_i,
    output logic [NUM_PINS-1:0] dgpio_o,
    output logic [NUM_PINS-1:0] dgpio_t,
    output logic [NUM_PINS-1:0] in_level,
    output logic [NUM_PINS-1:0] pulse_busy,
    output logic [NUM_PINS-1:0] irq_status,
    output logic                irq
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [NUM_PINS-1:0] s1;
    logic [NUM_PINS-1:0] s2;
    logic [NUM_PINS-1:0] out_q;
    logic [NUM_PINS-1:0] lvl_chg;
    logic [NUM_PINS-1:0] ev_set;
    logic [FILT_W-1:0]   filt_cnt  [NUM_PINS];
    logic [PULSE_W-1:0]  pulse_cnt [NUM_PINS];
    state_t              state     [NUM_PINS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dgpio_t <= '1;
            out_q   <= '0;
            s1      <= '0;
            s2      <= '0;
        end else begin
            dgpio_t <= ~cfg_dir;
            out_q   <= cfg_out;
            s1      <= dgpio_i;
            s2      <= s1;
        end
    end

    // A pin commits its new level once the mismatch has lasted L+1 cycles.
    always_comb begin
        lvl_chg = '0;
        ev_set  = '0;
        for (int n = 0; n < NUM_PINS; n++) begin
            lvl_chg[n] = (s2[n] != in_level[n]) && (filt_cnt[n] >= cfg_filt_len);
            ev_set[n]  = lvl_chg[n] && dgpio_t[n] &&
                         (s2[n] ? cfg_rise_en[n] : cfg_fall_en[n]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_level <= '0;
            for (int n = 0; n < NUM_PINS; n++) begin
                filt_cnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_PINS; n++) begin
                if (s2[n] == in_level[n]) begin
                    filt_cnt[n] <= '0;
                end else if (lvl_chg[n]) begin
                    in_level[n] <= s2[n];
                    filt_cnt[n] <= '0;
                end else begin
                    filt_cnt[n] <= filt_cnt[n] + FILT_W'(1);
                end
            end
        end
    end

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~irq_clr) | ev_set;
            irq        <= |irq_status;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_PINS; n++) begin
                state[n]     <= IDLE;
                pulse_cnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_PINS; n++) begin
                case (state[n])
                    IDLE: begin
                        if (pulse_start[n] && (pulse_len != '0)) begin
                            state[n]     <= ACTIVE;
                            pulse_cnt[n] <= pulse_len - PULSE_W'(1);
                        end
                    end
                    ACTIVE: begin
                        if (pulse_start[n] && (pulse_len != '0)) begin
                            pulse_cnt[n] <= pulse_len - PULSE_W'(1);
                        end else if (pulse_cnt[n] == '0) begin
                            state[n] <= IDLE;
                        end else begin
                            pulse_cnt[n] <= pulse_cnt[n] - PULSE_W'(1);
                        end
                    end
                    default: begin
                        state[n] <= IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        pulse_busy = '0;
        for (int n = 0; n < NUM_PINS; n++) begin
            pulse_busy[n] = (state[n] == ACTIVE);
        end
    end

    assign dgpio_o = out_q ^ pulse_busy;

endmodule

// File: tb/tb_adrv9001_dgpio_ctrl.sv
// Directed bench for adrv9001_dgpio_ctrl: filter timing, events,
// pulse lengths/retrigger, output-pin masking and async reset.
module tb_adrv9001_dgpio_ctrl;

    localparam int NP = 16;
    localparam int FW = 8;
    localparam int PW = 16;

    logic          clk;
    logic          rst;
    logic [NP-1:0] cfg_dir;
    logic [NP-1:0] cfg_out;
    logic [FW-1:0] cfg_filt_len;
    logic [NP-1:0] cfg_rise_en;
    logic [NP-1:0] cfg_fall_en;
    logic [NP-1:0] irq_clr;
    logic [NP-1:0] pulse_start;
    logic [PW-1:0] pulse_len;
    logic [NP-1:0] dgpio_i;
    logic [NP-1:0] dgpio_o;
    logic [NP-1:0] dgpio_t;
    logic [NP-1:0] in_level;
    logic [NP-1:0] pulse_busy;
    logic [NP-1:0] irq_status;
    logic          irq;

    int vectors;
    int miscompares;
    int hi;
    logic [NP-1:0] pat [10];

    adrv9001_dgpio_ctrl #(
        .NUM_PINS (NP),
        .FILT_W   (FW),
        .PULSE_W  (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_dir      (cfg_dir),
        .cfg_out      (cfg_out),
        .cfg_filt_len (cfg_filt_len),
        .cfg_rise_en  (cfg_rise_en),
        .cfg_fall_en  (cfg_fall_en),
        .irq_clr      (irq_clr),
        .pulse_start  (pulse_start),
        .pulse_len    (pulse_len),
        .dgpio_i      (dgpio_i),
        .dgpio_o      (dgpio_o),
        .dgpio_t      (dgpio_t),
        .in_level     (in_level),
        .pulse_busy   (pulse_busy),
        .irq_status   (irq_status),
        .irq          (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        cfg_dir      = '0;
        cfg_out      = '0;
        cfg_filt_len = '0;
        cfg_rise_en  = '0;
        cfg_fall_en  = '0;
        irq_clr      = '0;
        pulse_start  = '0;
        pulse_len    = '0;
        dgpio_i      = '0;
        pat = '{16'hA5C3, 16'h5A3C, 16'hFFFF, 16'h0000, 16'h0001,
                16'h8000, 16'h1234, 16'hEDCB, 16'h0F0F, 16'hF0F0};
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_t",      32'(dgpio_t),    32'hFFFF);
        chk("rst_o",      32'(dgpio_o),    32'h0);
        chk("rst_lvl",    32'(in_level),   32'h0);
        chk("rst_busy",   32'(pulse_busy), 32'h0);
        chk("rst_status", 32'(irq_status), 32'h0);
        chk("rst_irq",    32'(irq),        32'h0);

        // L=4 glitch rejection and acceptance on pin 3
        cfg_filt_len = 8'd4;
        dgpio_i[3] = 1'b1;
        repeat (4) tick();
        dgpio_i[3] = 1'b0;
        repeat (8) tick();
        chk("glitch4", 32'(in_level), 32'h0);
        dgpio_i[3] = 1'b1;
        repeat (5) tick();
        dgpio_i[3] = 1'b0;
        tick();
        chk("pulse5_e6", 32'(in_level), 32'h0);
        tick();
        chk("pulse5_e7", 32'(in_level), 32'h0008);
        repeat (10) tick();
        chk("pulse5_fall", 32'(in_level), 32'h0);

        // rise event on pin 0, clear colliding with a new rise
        cfg_filt_len = 8'd0;
        cfg_rise_en  = 16'h0001;
        dgpio_i[0] = 1'b1;
        tick();
        tick();
        chk("rise_e2", 32'(irq_status), 32'h0);
        tick();
        chk("rise_e3", 32'(irq_status), 32'h0001);
        chk("irq_lag", 32'(irq), 32'h0);
        tick();
        chk("irq_set", 32'(irq), 32'h1);
        dgpio_i[0] = 1'b0;
        repeat (4) tick();
        chk("no_fall_ev", 32'(irq_status), 32'h0001);
        dgpio_i[0] = 1'b1;
        tick();
        tick();
        irq_clr = 16'h0001;
        tick();
        irq_clr = '0;
        chk("set_wins", 32'(irq_status), 32'h0001);
        irq_clr = 16'h0001;
        tick();
        irq_clr = '0;
        chk("clr", 32'(irq_status), 32'h0);
        tick();
        chk("irq_clr", 32'(irq), 32'h0);

        // 10-cycle pulse on output pin 5, then retrigger
        cfg_dir[5] = 1'b1;
        pulse_len  = 16'd10;
        tick();
        chk("dir5", 32'(dgpio_t), 32'hFFDF);
        pulse_start[5] = 1'b1;
        tick();
        pulse_start = '0;
        chk("busy5", 32'(pulse_busy), 32'h0020);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (dgpio_o[5]) hi++;
            tick();
        end
        chk("pulse_len10", 32'(hi), 32'd10);
        chk("pulse_done", 32'(pulse_busy), 32'h0);
        pulse_start[5] = 1'b1;
        tick();
        pulse_start = '0;
        repeat (5) tick();
        pulse_start[5] = 1'b1;
        tick();
        pulse_start = '0;
        hi = 6;
        for (int i = 0; i < 30; i++) begin
            if (dgpio_o[5]) hi++;
            tick();
        end
        chk("retrig16", 32'(hi), 32'd16);

        // zero-length pulse ignored; output pad toggles raise no event
        pulse_len = 16'd0;
        pulse_start[5] = 1'b1;
        tick();
        pulse_start = '0;
        chk("len0_busy", 32'(pulse_busy), 32'h0);
        chk("len0_o",    32'(dgpio_o),    32'h0);
        cfg_rise_en = 16'hFFFF;
        cfg_fall_en = 16'hFFFF;
        dgpio_i[5] = 1'b1;
        repeat (5) tick();
        chk("outpin_lvl",  32'(in_level),   32'h0021);
        chk("outpin_rise", 32'(irq_status), 32'h0);
        dgpio_i[5] = 1'b0;
        repeat (5) tick();
        chk("outpin_fall", 32'(irq_status), 32'h0);
        cfg_rise_en = '0;
        cfg_fall_en = '0;

        // all 16 pins as inputs, L=0: 3-cycle lag, independent pins
        cfg_dir = '0;
        tick();
        for (int i = 0; i < 12; i++) begin
            dgpio_i = pat[(i < 10) ? i : 9];
            tick();
            if (i >= 2) chk($sformatf("track%0d", i - 2), 32'(in_level), 32'(pat[i - 2]));
        end

        // async reset in the middle of a pulse with events pending
        dgpio_i = '0;
        cfg_dir[5] = 1'b1;
        repeat (4) tick();
        cfg_rise_en = 16'hFFFF;
        dgpio_i = 16'hFFFF;
        repeat (3) tick();
        chk("all_rise", 32'(irq_status), 32'hFFDF);
        tick();
        chk("all_irq", 32'(irq), 32'h1);
        pulse_len = 16'd10;
        pulse_start[5] = 1'b1;
        tick();
        pulse_start = '0;
        chk("pre_rst_busy", 32'(pulse_busy), 32'h0020);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_t",      32'(dgpio_t),    32'hFFFF);
        chk("arst_o",      32'(dgpio_o),    32'h0);
        chk("arst_busy",   32'(pulse_busy), 32'h0);
        chk("arst_status", 32'(irq_status), 32'h0);
        chk("arst_irq",    32'(irq),        32'h0);
        chk("arst_lvl",    32'(in_level),   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
